multi_lane_bin_avg: RTL and testbench
=====================================

// Module: multi_lane_bin_avg
// PURPOSE
//  Streaming per-bin spectral averager; successor to the fixed 4-lane running averager.
//  Accepts FFT frames of NUM_BINS bins, LANES bins/cycle, sums 2^log2_avg consecutive frames
//  per bin in an internal accumulator RAM, and emits one averaged frame per window.
//  Sits between the FFT core and the readout/packetiser; no backpressure (FFT cannot stall).
// PARAMETERS
//  DATA_W        16   unsigned bin width (input and output)
//  LANES          4   bins presented per valid cycle
//  NUM_BINS    1024   bins per frame; must be a multiple of LANES
//  MAX_LOG2_AVG   8   largest supported log2 of the averaging depth
// PORTS
//  clk        in   1                 single clock
//  rst        in   1                 synchronous, active-high reset
//  log2_avg   in   $clog2(MAX_LOG2_AVG+1)  averaging depth k (2^k frames); sampled at window start
//  in_data    in   [LANES-1:0][DATA_W-1:0]  lane i = bin word_idx*LANES+i
//  fft_valid  in   1                 in_data valid this cycle
//  fft_last   in   1                 qualifies last word of a frame (ignored without fft_valid)
//  out_data   out  [LANES-1:0][DATA_W-1:0]  averaged bins, same lane order
//  out_valid  out  1                 out_data valid
//  out_last   out  1                 last word of averaged frame
//  frame_err  out  1                 one-cycle pulse: framing violation, window discarded
// BEHAVIOUR
//  - FRAME_WORDS = NUM_BINS/LANES; ACC_W = DATA_W+MAX_LOG2_AVG (sum can never overflow).
//  - Counters: word_cnt 0..FRAME_WORDS-1 (advances on fft_valid, wraps on frame end);
//    frame_cnt 0..2^k-1 (advances at frame end). k latched when word_cnt=0 and frame_cnt=0.
//  - Frame class: FIRST (frame_cnt=0): acc[word] <= in; MID: acc[word] <= acc[word]+in;
//    LAST (frame_cnt=2^k-1): out <= (acc[word]+in) >> k, acc not needed. k=0: every frame
//    is FIRST and LAST; out = in.
//  - Latency: out_valid exactly 1 cycle after the fft_valid cycle of the LAST-frame word;
//    out_last = registered (fft_valid & fft_last) of that word. Output gaps mirror input gaps.
//  - Accumulator read for word w+1 must be available while writing w: read-before-write per
//    cycle; back-to-back fft_valid at full rate is required.
//  - Framing errors (frame_err pulses 1 cycle after the offending word):
//    fft_last with word_cnt != FRAME_WORDS-1, or word_cnt = FRAME_WORDS-1 without fft_last.
//    On error: word_cnt, frame_cnt <= 0, no out_valid for that word, window discarded; next
//    fft_valid word starts a new window as word 0 of a FIRST frame (k re-latched).
//  - log2_avg > MAX_LOG2_AVG: clamped to MAX_LOG2_AVG at latch time.
//  - log2_avg changes mid-window: ignored until next window start.
//  - Reset (any time, incl. mid-window): out_data=0, out_valid=0, out_last=0, frame_err=0,
//    word_cnt=0, frame_cnt=0, k latched from log2_avg at next window start. Accumulator RAM
//    contents need no reset (FIRST frame overwrites).
// CONFIGURATION
//  - AVG_ROUND_EN defined: out = (sum + (k>0 ? 2^(k-1) : 0)) >> k, round-half-up; sum width
//    ACC_W+1 internally so it cannot wrap; result saturates at 2^DATA_W-1.
//  - AVG_ROUND_EN undefined: plain truncation (sum >> k); no saturation logic.
// STRUCTURE
//  - Package bin_avg_pkg: FRAME_WORDS/ACC_W helper functions, frame-class enum
//    {FRM_FIRST, FRM_MID, FRM_LAST}, lane-vector typedefs.
//  - Sub-module bin_avg_lane (one per lane, generate loop): accumulator RAM (FRAME_WORDS x
//    ACC_W), add/shift/round datapath; top owns counters, frame classing, error detect.
// TESTING (LANES=4, NUM_BINS=16, DATA_W=16, MAX_LOG2_AVG=8)
//  1 k=2, 4 frames, all bins 10,30,20,30 per frame respectively -> one frame, all bins 22
//    (trunc; 23 with AVG_ROUND_EN), out_valid 4 cycles, out_last on 4th.
//  2 k=0, in word0=FFFF,AAAA,BBBB,CCCC -> out identical 1 cycle later every frame.
//  3 k=8, 256 frames all bins FFFF -> out FFFF (no overflow); with AVG_ROUND_EN also FFFF.
//  4 fft_last on word 2 of frame 1 (k=1) -> frame_err pulse, no output; following two clean
//    frames of 4 and 8 -> output 6.
//  5 rst asserted mid-frame 2 of k=2 window, then 4 frames of 100 -> outputs all 0 while in
//    reset, then one frame of 100; log2_avg changed to 0 mid-window -> takes effect next window.
//  6 fft_valid gapped 1-in-3 cycles, k=1 -> out_valid pattern follows input gaps, values exact.

Source files
------------

// File: rtl/bin_avg_pkg.sv
// Shared types and sizing helpers for the multi-lane per-bin spectral averager.
package bin_avg_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_LANES  = 4;

    // Which part of the averaging window the current frame belongs to
    typedef enum logic [1:0] {
        FRM_FIRST,
        FRM_MID,
        FRM_LAST
    } frm_class_e;

    // Lane vector for the default build (lane i in bits [i*DATA_W +: DATA_W])
    typedef logic [DEF_LANES-1:0][DEF_DATA_W-1:0] lane_vec_t;

    // Words per frame: each word carries LANES consecutive bins
    function automatic int unsigned frame_words(input int unsigned num_bins,
                                                input int unsigned lanes);
        return num_bins / lanes;
    endfunction

    // Accumulator width wide enough for 2^max_log2_avg full-scale samples
    function automatic int unsigned acc_w(input int unsigned data_w,
                                          input int unsigned max_log2_avg);
        return data_w + max_log2_avg;
    endfunction

    // Counter width able to index n entries (never zero)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_lane_bin_avg_lane.sv
// One lane of the bin averager: accumulator RAM plus add / shift (/ round) datapath.
// AVG_ROUND_EN selects round-half-up with saturation instead of truncation.
module bin_avg_lane #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned KW          = 4,
    parameter int unsigned FRAME_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr,
    input  logic [AW-1:0]     wr_addr,
    input  logic              acc_we,
    input  logic              out_en,
    input  logic              use_acc,
    input  logic [KW-1:0]     k,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data
);

    logic [ACC_W-1:0]  mem [FRAME_WORDS];
    logic [ACC_W-1:0]  rd_q;
    logic [ACC_W-1:0]  sum_c;
    logic [DATA_W-1:0] avg_c;

    // Running sum; the first frame of a window ignores stale RAM contents
    always_comb begin
        sum_c = ACC_W'(in_data);
        if (use_acc) begin
            sum_c = rd_q + ACC_W'(in_data);
        end
    end

`ifdef AVG_ROUND_EN
    logic [ACC_W:0] rbias_c;
    logic [ACC_W:0] rsum_c;
    logic [ACC_W:0] rshift_c;

    // Round half up with one guard bit, then clamp to the output range
    always_comb begin
        rbias_c = '0;
        if (k != '0) begin
            rbias_c = (ACC_W+1)'(1) << (k - KW'(1));
        end
        rsum_c   = {1'b0, sum_c} + rbias_c;
        rshift_c = rsum_c >> k;
        avg_c    = DATA_W'(rshift_c);
        if (rshift_c > (ACC_W+1)'({DATA_W{1'b1}})) begin
            avg_c = '1;
        end
    end
`else
    // Plain truncating divide by 2^k
    always_comb begin
        avg_c = DATA_W'(sum_c >> k);
    end
`endif

    // Accumulator RAM write port (contents need no reset: first frame overwrites)
    always_ff @(posedge clk) begin
        if (acc_we) begin
            mem[wr_addr] <= sum_c;
        end
    end

    // Prefetch next word's partial sum; bypass when it is being written this cycle
    always_ff @(posedge clk) begin
        if (acc_we && (wr_addr == rd_addr)) begin
            rd_q <= sum_c;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    // Registered averaged output, held between output words
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (out_en) begin
            out_data <= avg_c;
        end
    end

endmodule

// File: rtl/multi_lane_bin_avg.sv
// Streaming per-bin spectral averager: sums 2^k FFT frames per bin, emits one averaged frame.
// Optional macro AVG_ROUND_EN: round-half-up with saturation instead of truncation.
module multi_lane_bin_avg
    import bin_avg_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned LANES        = 4,
    parameter int unsigned NUM_BINS     = 1024,
    parameter int unsigned MAX_LOG2_AVG = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [$clog2(MAX_LOG2_AVG+1)-1:0]  log2_avg,
    input  logic [LANES-1:0][DATA_W-1:0]       in_data,
    input  logic                               fft_valid,
    input  logic                               fft_last,
    output logic [LANES-1:0][DATA_W-1:0]       out_data,
    output logic                               out_valid,
    output logic                               out_last,
    output logic                               frame_err
);

    localparam int unsigned FRAME_WORDS = frame_words(NUM_BINS, LANES);
    localparam int unsigned ACC_W       = acc_w(DATA_W, MAX_LOG2_AVG);
    localparam int unsigned WCW         = cnt_w(FRAME_WORDS);
    localparam int unsigned FCW         = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;
    localparam int unsigned KW          = $clog2(MAX_LOG2_AVG + 1);

    logic [WCW-1:0] word_cnt;
    logic [FCW-1:0] frame_cnt;
    logic [KW-1:0]  k_q;

    logic [WCW-1:0] word_cnt_nxt_c;
    logic [WCW-1:0] rd_addr_c;
    logic [KW-1:0]  k_clamp_c;
    logic [KW-1:0]  k_c;
    logic [FCW-1:0] last_idx_c;
    frm_class_e     cls_c;
    logic           win_start_c;
    logic           end_word_c;
    logic           err_c;
    logic           acc_we_c;
    logic           out_en_c;
    logic           use_acc_c;

    // Window-start depth latch, frame classing and framing check for the current word
    always_comb begin
        win_start_c = (word_cnt == '0) && (frame_cnt == '0);
        k_clamp_c   = (log2_avg > KW'(MAX_LOG2_AVG)) ? KW'(MAX_LOG2_AVG) : log2_avg;
        k_c         = win_start_c ? k_clamp_c : k_q;
        last_idx_c  = FCW'(((FCW+1)'(1) << k_c) - (FCW+1)'(1));
        end_word_c  = (word_cnt == WCW'(FRAME_WORDS - 1));
        err_c       = fft_valid && (fft_last != end_word_c);

        cls_c = FRM_MID;
        if (frame_cnt == last_idx_c) begin
            cls_c = FRM_LAST;
        end else if (frame_cnt == '0) begin
            cls_c = FRM_FIRST;
        end

        use_acc_c = (frame_cnt != '0);
        acc_we_c  = fft_valid && !err_c && (cls_c != FRM_LAST);
        out_en_c  = fft_valid && !err_c && (cls_c == FRM_LAST);
    end

    // Next word index; also the RAM prefetch address for the following cycle
    always_comb begin
        word_cnt_nxt_c = word_cnt;
        if (fft_valid) begin
            if (err_c || end_word_c) begin
                word_cnt_nxt_c = '0;
            end else begin
                word_cnt_nxt_c = word_cnt + WCW'(1);
            end
        end
        rd_addr_c = rst ? '0 : word_cnt_nxt_c;
    end

    // Word / frame counters and latched averaging depth
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt  <= '0;
            frame_cnt <= '0;
            k_q       <= '0;
        end else begin
            word_cnt <= word_cnt_nxt_c;
            if (fft_valid && win_start_c) begin
                k_q <= k_clamp_c;
            end
            if (fft_valid) begin
                if (err_c) begin
                    frame_cnt <= '0;
                end else if (end_word_c) begin
                    frame_cnt <= (frame_cnt == last_idx_c) ? '0 : frame_cnt + FCW'(1);
                end
            end
        end
    end

    // Registered output qualifiers and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= out_en_c;
            out_last  <= out_en_c && fft_last;
            frame_err <= err_c;
        end
    end

    // One accumulator/datapath lane per bin position in the word
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bin_avg_lane #(
            .DATA_W      (DATA_W),
            .ACC_W       (ACC_W),
            .KW          (KW),
            .FRAME_WORDS (FRAME_WORDS),
            .AW          (WCW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .rd_addr  (rd_addr_c),
            .wr_addr  (word_cnt),
            .acc_we   (acc_we_c),
            .out_en   (out_en_c),
            .use_acc  (use_acc_c),
            .k        (k_c),
            .in_data  (in_data[i]),
            .out_data (out_data[i])
        );
    end

endmodule

// File: tb/tb_multi_lane_bin_avg.sv
// Directed self-checking bench for multi_lane_bin_avg (LANES=4, NUM_BINS=16).
module tb_multi_lane_bin_avg;
    import bin_avg_pkg::*;

`ifdef AVG_ROUND_EN
    localparam logic [15:0] EXP1 = 16'd23;
`else
    localparam logic [15:0] EXP1 = 16'd22;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  log2_avg;
    lane_vec_t   in_data;
    logic        fft_valid;
    logic        fft_last;
    lane_vec_t   out_data;
    logic        out_valid;
    logic        out_last;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    lane_vec_t t2 [4];
    lane_vec_t d;
    lane_vec_t e;

    always #5 clk = ~clk;

    multi_lane_bin_avg #(
        .DATA_W       (16),
        .LANES        (4),
        .NUM_BINS     (16),
        .MAX_LOG2_AVG (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .log2_avg  (log2_avg),
        .in_data   (in_data),
        .fft_valid (fft_valid),
        .fft_last  (fft_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One input word in one cycle; outputs for it are visible on return
    task automatic send_word(input lane_vec_t v, input logic l);
        in_data   = v;
        fft_valid = 1'b1;
        fft_last  = l;
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    task automatic idle();
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Full clean frame with all bins = v; optionally expect averaged output ev
    task automatic send_frame(input string tag, input logic [15:0] v,
                              input bit exp_out, input logic [15:0] ev);
        for (int w = 0; w < 4; w++) begin
            send_word({4{v}}, 1'(w == 3));
            check({tag, " valid"}, 64'(out_valid), 64'(exp_out));
            check({tag, " err"}, 64'(frame_err), 64'd0);
            if (exp_out) begin
                check({tag, " data"}, 64'(out_data), {4{ev}});
                check({tag, " last"}, 64'(out_last), 64'(w == 3));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        log2_avg  = 4'd2;
        in_data   = '0;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        t2[0] = {16'hCCCC, 16'hBBBB, 16'hAAAA, 16'hFFFF};
        t2[1] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        t2[2] = {16'h8000, 16'h7FFF, 16'h0000, 16'h1234};
        t2[3] = {16'hDEAD, 16'hBEEF, 16'h5555, 16'hA5A5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_last",  64'(out_last),  64'd0);
        check("rst frame_err", 64'(frame_err), 64'd0);
        check("rst out_data",  64'(out_data),  64'd0);
        rst = 1'b0;
        idle();

        // 1: k=2, frames 10,30,20,30 -> 22 (23 rounded)
        log2_avg = 4'd2;
        send_frame("t1f0", 16'd10, 1'b0, 16'd0);
        send_frame("t1f1", 16'd30, 1'b0, 16'd0);
        send_frame("t1f2", 16'd20, 1'b0, 16'd0);
        send_frame("t1f3", 16'd30, 1'b1, EXP1);
        idle();
        check("t1 gap valid", 64'(out_valid), 64'd0);

        // 2: k=0 passthrough, two frames
        log2_avg = 4'd0;
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < 4; w++) begin
                d = (f == 1) ? ~t2[w] : t2[w];
                send_word(d, 1'(w == 3));
                check("t2 valid", 64'(out_valid), 64'd1);
                check("t2 data",  64'(out_data),  64'(d));
                check("t2 last",  64'(out_last),  64'(w == 3));
            end
        end

        // 3: k=8, 256 full-scale frames -> FFFF
        log2_avg = 4'd8;
        for (int f = 0; f < 255; f++) begin
            send_frame("t3 acc", 16'hFFFF, 1'b0, 16'd0);
        end
        send_frame("t3 out", 16'hFFFF, 1'b1, 16'hFFFF);

        // 4a: early fft_last on word 2 of frame 1, k=1
        log2_avg = 4'd1;
        send_frame("t4 f0", 16'd50, 1'b0, 16'd0);
        for (int w = 0; w < 2; w++) begin
            send_word({4{16'd50}}, 1'b0);
            check("t4 f1 valid", 64'(out_valid), 64'd1);
            check("t4 f1 data",  64'(out_data),  {4{16'd50}});
        end
        send_word({4{16'd50}}, 1'b1);
        check("t4 err pulse", 64'(frame_err), 64'd1);
        check("t4 err noout", 64'(out_valid), 64'd0);
        send_frame("t4 clean4", 16'd4, 1'b0, 16'd0);
        send_frame("t4 clean8", 16'd8, 1'b1, 16'd6);

        // 4b: last word without fft_last
        for (int w = 0; w < 3; w++) begin
            send_word({4{16'd5}}, 1'b0);
            check("t4b noerr", 64'(frame_err), 64'd0);
        end
        send_word({4{16'd5}}, 1'b0);
        check("t4b err pulse", 64'(frame_err), 64'd1);
        check("t4b noout",     64'(out_valid), 64'd0);
        send_frame("t4b c2", 16'd2, 1'b0, 16'd0);
        send_frame("t4b c4", 16'd4, 1'b1, 16'd3);

        // 5: reset mid frame 2 of a k=2 window
        log2_avg = 4'd2;
        send_frame("t5 f0", 16'd7, 1'b0, 16'd0);
        send_frame("t5 f1", 16'd9, 1'b0, 16'd0);
        send_word({4{16'd11}}, 1'b0);
        send_word({4{16'd11}}, 1'b0);
        rst       = 1'b1;
        in_data   = {4{16'd100}};
        fft_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("t5 rst valid", 64'(out_valid), 64'd0);
            check("t5 rst data",  64'(out_data),  64'd0);
            check("t5 rst err",   64'(frame_err), 64'd0);
        end
        fft_valid = 1'b0;
        rst       = 1'b0;
        idle();
        send_frame("t5 w0", 16'd100, 1'b0, 16'd0);
        log2_avg = 4'd0;
        send_frame("t5 w1", 16'd100, 1'b0, 16'd0);
        send_frame("t5 w2", 16'd100, 1'b0, 16'd0);
        send_frame("t5 w3", 16'd100, 1'b1, 16'd100);
        send_frame("t5 k0", 16'd55, 1'b1, 16'd55);

        // 6: gapped input 1-in-3, k=1, per-bin distinct values
        log2_avg = 4'd1;
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < 4; w++) begin
                for (int i = 0; i < 4; i++) begin
                    d[i] = 16'(w * 4 + i + f * 100);
                    e[i] = 16'(w * 4 + i + 50);
                end
                send_word(d, 1'(w == 3));
                check("t6 valid", 64'(out_valid), 64'(f == 1));
                if (f == 1) begin
                    check("t6 data", 64'(out_data), 64'(e));
                    check("t6 last", 64'(out_last), 64'(w == 3));
                end
                for (int g = 0; g < 2; g++) begin
                    idle();
                    check("t6 gap", 64'(out_valid), 64'd0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
